xor_scrambler: RTL and testbench

- Parametrised, pipelined XOR datapath that scrambles or descrambles a DATA_W-bit stream with a Fibonacci LFSR keystream.
- Supports four modes: additive scramble/descramble, self-synchronous scramble, self-synchronous descramble, and bypass.
- Sits between a stream source and a serialiser or link, with valid/ready handshake on both sides and one-cycle latency.

---
 rtl/xor_scrambler.sv | 96 +++++++++
 tb/tb_xor_scrambler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_scrambler.sv
// xor_scrambler: one-stage valid/ready XOR datapath driven by a Fibonacci LFSR
// keystream. Supports additive, self-synchronous scramble/descramble and bypass.
// The LFSR is advanced DATA_W steps per accepted beat, fully unrolled.
module xor_scrambler #(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 7,
    parameter logic [LFSR_W-1:0] TAPS   = 7'h60,
    parameter logic [LFSR_W-1:0] SEED   = 7'h7F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof
);

    typedef enum logic [1:0] {
        MODE_ADD      = 2'd0,
        MODE_SS_SCR   = 2'd1,
        MODE_SS_DESCR = 2'd2,
        MODE_BYPASS   = 2'd3
    } mode_t;

    mode_t             mode_q;
    mode_t             beat_mode;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] step_s;
    logic [LFSR_W-1:0] next_lfsr;
    logic [DATA_W-1:0] proc_data;
    logic              fb;
    logic              accept;

    // Single output register: a new beat may enter whenever the slot is empty
    // or is being drained on this same edge.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Unrolled keystream: a sof beat starts from SEED with the freshly sampled
    // mode, otherwise the stored state and latched mode carry on.
    always_comb begin
        step_s    = in_sof ? SEED : lfsr_q;
        beat_mode = in_sof ? mode_t'(mode) : mode_q;
        proc_data = '0;
        fb        = 1'b0;
        for (int j = 0; j < DATA_W; j++) begin
            fb = ^(step_s & TAPS);
            case (beat_mode)
                MODE_ADD: begin
                    proc_data[j] = in_data[j] ^ fb;
                    step_s       = {step_s[LFSR_W-2:0], fb};
                end
                MODE_SS_SCR: begin
                    proc_data[j] = in_data[j] ^ fb;
                    step_s       = {step_s[LFSR_W-2:0], proc_data[j]};
                end
                MODE_SS_DESCR: begin
                    proc_data[j] = in_data[j] ^ fb;
                    step_s       = {step_s[LFSR_W-2:0], in_data[j]};
                end
                default: begin
                    proc_data[j] = in_data[j];
                end
            endcase
        end
        next_lfsr = step_s;
    end

    // Output register, LFSR state and latched mode only move on an accepted
    // beat; a stalled output leaves everything frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            lfsr_q    <= SEED;
            mode_q    <= MODE_ADD;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= proc_data;
            out_sof   <= in_sof;
            lfsr_q    <= next_lfsr;
            if (in_sof) begin
                mode_q <= beat_mode;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_scrambler.sv
// Testbench for xor_scrambler: scenario tasks with a scoreboard queue fed by a
// bit-serial reference model at the moment each beat is accepted.
module tb_xor_scrambler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sof;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sof;

    // Second instance with a different seed, used as the self-sync descrambler.
    logic [1:0] d_mode;
    logic       d_in_valid;
    logic       d_in_ready;
    logic [7:0] d_in_data;
    logic       d_in_sof;
    logic       d_out_valid;
    logic       d_out_ready;
    logic [7:0] d_out_data;
    logic       d_out_sof;

    int         vectors = 0;
    int         miscompares = 0;

    logic [7:0] sb[$];
    logic [6:0] m_lfsr;
    logic [1:0] m_mode;

    localparam logic [6:0] SEED = 7'h7F;

    xor_scrambler u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof)
    );

    xor_scrambler #(.SEED(7'h15)) u_desc (
        .clk(clk), .rst_n(rst_n), .mode(d_mode),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_sof(d_in_sof),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .out_sof(d_out_sof)
    );

    always #5 clk = ~clk;

    // Bit-serial reference for x^7+x^6+1: returns {new_state, output_word}.
    function automatic logic [14:0] ref_beat(input logic [6:0] s0, input logic [1:0] md,
                                             input logic [7:0] d);
        logic [6:0] s;
        logic [7:0] o;
        logic       f;
        s = s0;
        o = '0;
        for (int j = 0; j < 8; j++) begin
            f = s[6] ^ s[5];
            if (md == 2'd3) begin
                o[j] = d[j];
            end else begin
                o[j] = d[j] ^ f;
                if (md == 2'd0)      s = {s[5:0], f};
                else if (md == 2'd1) s = {s[5:0], o[j]};
                else                 s = {s[5:0], d[j]};
            end
        end
        return {s, o};
    endfunction

    task automatic model_reset();
        m_lfsr = SEED;
        m_mode = 2'd0;
        sb.delete();
    endtask

    // Present one beat to u_dut, wait (bounded) for acceptance, push the model
    // result, and return 1 time unit after the accepting edge.
    task automatic drive_beat(input logic [7:0] d, input logic sof, input logic [1:0] md);
        int          t;
        logic [14:0] r;
        logic [6:0]  s;
        logic [1:0]  mm;
        t        = 0;
        in_data  = d;
        in_sof   = sof;
        mode     = md;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: in_ready=%b required 1", in_ready);
        end
        s  = sof ? SEED : m_lfsr;
        mm = sof ? md : m_mode;
        r  = ref_beat(s, mm, d);
        m_lfsr = r[14:8];
        if (sof) m_mode = md;
        sb.push_back(r[7:0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        vectors++;
        if (out_data !== 8'h00) begin
            miscompares++; $display("FAIL reset_out_data: got %h want 00", out_data);
        end
        vectors++;
        if (out_sof !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_sof: got %b want 0", out_sof);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_additive();
        logic [7:0] e;
        drive_beat(8'h00, 1'b1, 2'd0);
        e = sb.pop_front();
        vectors++;
        if (out_data !== 8'h40 || out_data !== e || out_valid !== 1'b1 || out_sof !== 1'b1) begin
            miscompares++;
            $display("FAIL add_beat1: got %h v=%b sof=%b want 40 (model %h) v=1 sof=1",
                     out_data, out_valid, out_sof, e);
        end
        vectors++;
        if (u_dut.lfsr_q !== 7'h02) begin
            miscompares++; $display("FAIL add_lfsr_after1: got %h want 02", u_dut.lfsr_q);
        end
        drive_beat(8'h00, 1'b0, 2'd0);
        e = sb.pop_front();
        vectors++;
        if (out_data !== 8'h30 || out_data !== e || out_sof !== 1'b0) begin
            miscompares++;
            $display("FAIL add_beat2: got %h sof=%b want 30 (model %h) sof=0", out_data, out_sof, e);
        end
    endtask

    task automatic test_additive_roundtrip();
        logic [7:0] orig[16];
        logic [7:0] scr[16];
        logic [7:0] e;
        drive_beat(8'h40, 1'b1, 2'd0);
        e = sb.pop_front();
        vectors++;
        if (out_data !== 8'h00 || out_data !== e) begin
            miscompares++; $display("FAIL add_rt_beat1: got %h want 00", out_data);
        end
        drive_beat(8'h30, 1'b0, 2'd0);
        e = sb.pop_front();
        vectors++;
        if (out_data !== 8'h00 || out_data !== e) begin
            miscompares++; $display("FAIL add_rt_beat2: got %h want 00", out_data);
        end
        for (int k = 0; k < 16; k++) orig[k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 16; k++) begin
            drive_beat(orig[k], k == 0, 2'd0);
            e = sb.pop_front();
            scr[k] = out_data;
            vectors++;
            if (out_data !== e) begin
                miscompares++; $display("FAIL add_rand_scr[%0d]: got %h want %h", k, out_data, e);
            end
        end
        for (int k = 0; k < 16; k++) begin
            drive_beat(scr[k], k == 0, 2'd0);
            void'(sb.pop_front());
            vectors++;
            if (out_data !== orig[k]) begin
                miscompares++; $display("FAIL add_rand_rt[%0d]: got %h want %h", k, out_data, orig[k]);
            end
        end
    endtask

    task automatic test_self_sync();
        logic [7:0] orig[6];
        logic [7:0] scr[6];
        logic [7:0] e;
        int         t;
        for (int k = 0; k < 6; k++) orig[k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 6; k++) begin
            drive_beat(orig[k], k == 0, 2'd1);
            e = sb.pop_front();
            scr[k] = out_data;
            vectors++;
            if (out_data !== e) begin
                miscompares++; $display("FAIL ss_scr[%0d]: got %h want %h", k, out_data, e);
            end
        end
        for (int k = 0; k < 6; k++) begin
            t          = 0;
            d_in_data  = scr[k];
            d_in_sof   = (k == 0);
            d_mode     = 2'd2;
            d_in_valid = 1'b1;
            while (!d_in_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            @(posedge clk); #1;
            d_in_valid = 1'b0;
            d_in_sof   = 1'b0;
            if (k >= 1) begin
                vectors++;
                if (d_out_data !== orig[k] || d_out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ss_descr[%0d]: got %h v=%b want %h v=1", k, d_out_data, d_out_valid, orig[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        logic [7:0] held;
        logic [14:0] r;
        drive_beat(8'h12, 1'b1, 2'd0);
        e = sb.pop_front();
        vectors++;
        if (out_data !== e) begin
            miscompares++; $display("FAIL bp_first: got %h want %h", out_data, e);
        end
        held      = out_data;
        out_ready = 1'b0;
        in_data   = 8'h34;
        in_sof    = 1'b0;
        mode      = 2'd0;
        in_valid  = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_data !== held || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_stall[%0d]: in_ready=%b data=%h v=%b want 0 %h 1",
                         c, in_ready, out_data, out_valid, held);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        r      = ref_beat(m_lfsr, m_mode, 8'h34);
        m_lfsr = r[14:8];
        sb.push_back(r[7:0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (out_data !== e || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL bp_release: got %h v=%b want %h v=1", out_data, out_valid, e);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] e;
        drive_beat(8'hA5, 1'b1, 2'd3);
        e = sb.pop_front();
        vectors++;
        if (out_data !== 8'hA5 || out_data !== e) begin
            miscompares++; $display("FAIL byp_beat1: got %h want a5", out_data);
        end
        drive_beat(8'h3C, 1'b0, 2'd0);
        e = sb.pop_front();
        vectors++;
        if (out_data !== 8'h3C || out_data !== e) begin
            miscompares++; $display("FAIL byp_mode_latch: got %h want 3c", out_data);
        end
        drive_beat(8'h00, 1'b1, 2'd0);
        e = sb.pop_front();
        vectors++;
        if (out_data !== 8'h40 || out_data !== e) begin
            miscompares++; $display("FAIL byp_next_sof: got %h want 40", out_data);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] e;
        drive_beat(8'h00, 1'b1, 2'd0);
        void'(sb.pop_front());
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_valid: got %b want 0", out_valid);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        drive_beat(8'h00, 1'b0, 2'd0);
        e = sb.pop_front();
        vectors++;
        if (out_data !== 8'h40 || out_data !== e) begin
            miscompares++; $display("FAIL rst_mid_next: got %h want 40", out_data);
        end
    endtask

    initial begin
        mode        = 2'd0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_sof      = 1'b0;
        out_ready   = 1'b1;
        d_mode      = 2'd0;
        d_in_valid  = 1'b0;
        d_in_data   = 8'h00;
        d_in_sof    = 1'b0;
        d_out_ready = 1'b1;
        test_reset();
        test_additive();
        test_additive_roundtrip();
        test_self_sync();
        test_backpressure();
        test_bypass();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
